unsigned_div_seq: RTL and testbench
===================================

Name: unsigned_div_seq

Overview:
Parametrised multi-cycle unsigned integer divider, radix-2 restoring, one quotient bit per clock. It is the next generation of the fixed 48/24-bit divider used by the floating-point unit's mantissa-divide path. It generalises the dividend and divisor widths, adds valid/ready handshakes on both input and output, and adds a divide-by-zero flag. The FP divide sequencer instantiates it between operand alignment and normalisation.

Parameters:
DVD_W, 48, dividend and quotient width in bits (>=2)
DVS_W, 24, divisor and remainder width in bits (>=1, <=DVD_W)
CNT_W, $clog2(DVD_W+1), iteration-counter width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operands valid
in_ready  out  1  divider idle, operands may be accepted
dividend  in  DVD_W  unsigned dividend
divisor  in  DVS_W  unsigned divisor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
quotient  out  DVD_W  floor(dividend/divisor)
remainder  out  DVS_W  dividend mod divisor
div_by_zero  out  1  result came from divisor==0

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; div_by_zero=0; counter=0.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, capture operands. If divisor==0, go to DONE. Otherwise go to CALC with counter=DVD_W.
  - CALC: each cycle, shift {partial_rem, dividend_shreg} left by 1.
    - Trial subtract: partial_rem (DVS_W+1 bits) minus divisor.
    - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
    - Decrement counter. When counter reaches 1 on this cycle, go to DONE.
  - DONE: out_valid=1, with quotient, remainder and div_by_zero stable. On out_ready, go to IDLE.
    - Outputs keep their last values after leaving DONE. Only out_valid drops.
- Handshake rules:
  - in_ready is high only in IDLE. in_valid outside IDLE is ignored; operands are not queued.
  - out_valid is held until out_ready is sampled high. No result is ever dropped.
  - out_ready while out_valid=0 has no effect.
  - A new operand can be accepted no earlier than the cycle after the out handshake.
- Latency:
  - Accept edge is T. CALC occupies DVD_W cycles. out_valid is high from edge T+DVD_W+1.
  - With DVD_W=48, the result is visible 49 cycles after accept.
- Width rules:
  - Internal partial remainder is DVS_W+1 bits so the trial subtract cannot overflow.
  - Final remainder < divisor, so it fits DVS_W bits exactly.
- Boundary conditions:
  - divisor==0: no CALC. out_valid is high from edge T+1; quotient = all ones; remainder = 0; div_by_zero=1.
  - dividend < divisor: quotient=0, remainder=dividend truncated to DVS_W bits.
  - dividend==0 with nonzero divisor: quotient=0, remainder=0, full latency.
  - divisor==1: quotient=dividend, remainder=0.
  - Maximum operands: 2^48-1 divided by 2^24-1 gives quotient 0x1000001, remainder 0. No overflow.
  - rst asserted mid-CALC or in DONE: immediate abort to reset values. The pending result is discarded.
  - in_valid and rst asserted together: rst wins.

Optional Feature:
Macro: UNSIGNED_DIV_EARLY_TERM_EN
- Defined:
  - On accept, compute the leading-zero count L of the dividend.
  - Pre-shift dividend_shreg left by L and load counter = max(1, DVD_W-L).
  - Results are identical; latency becomes max(1, DVD_W-L)+1 cycles.
  - A dividend of 0 finishes in 2 cycles. Divide-by-zero latency is unchanged.
- Not defined:
  - Fixed DVD_W-cycle CALC and no leading-zero logic in the netlist.

Test Plan:
- Basic divide: 1000003 / 7 -> quotient 142857, remainder 4, div_by_zero 0. out_valid first high 49 cycles after accept, or 21 cycles with UNSIGNED_DIV_EARLY_TERM_EN (20 significant bits).
- Maximum operands: 48'hFFFF_FFFF_FFFF / 24'hFF_FFFF -> quotient 48'h1000001, remainder 0.
- Divide by zero and small dividend:
  - 12345 / 0 -> out_valid at T+1, quotient 48'hFFFF_FFFF_FFFF, remainder 0, div_by_zero 1.
  - 5 / 9 -> quotient 0, remainder 5.
- Output backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready stays 0.
  - A new in_valid during that window is ignored.
  - Release out_ready -> in_ready=1 on the next cycle.
- Reset mid-operation: assert rst 20 cycles into CALC -> outputs immediately 0, in_ready=1. A subsequent 100/10 -> quotient 10, remainder 0.
- Back-to-back ops with out_ready tied high: 3 consecutive divides (1000003/7, 255/16, 1/1) -> results 142857 r4, 15 r15, 1 r0, in order, none lost.

Source files
------------

// File: rtl/unsigned_div_seq.sv
// ---------------------------------------------------------------------------
// unsigned_div_seq
//   Multi-cycle radix-2 restoring unsigned divider. It produces one quotient
//   bit per clock and has valid/ready handshakes on both the operand side and
//   the result side. A zero divisor skips the iteration and returns
//   quotient = all ones, remainder = 0 and div_by_zero = 1.
//
//   Latency, counted from the cycle in which in_valid is accepted:
//     out_valid is high in cycle N+1, where N is the number of CALC cycles
//     (N = DVD_W; with early termination N = max(1, DVD_W - lzc(dividend))).
//     For a zero divisor, out_valid is high in the next cycle.
//
//   Optional feature (macro UNSIGNED_DIV_EARLY_TERM_EN):
//     At accept, the dividend's leading zeros are skipped. The shift register
//     is pre-shifted and the iteration count is reduced to match. Results are
//     identical to the full-length run.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   in_valid     operands valid              in_ready   idle, operands accepted
//   dividend     DVD_W-bit unsigned dividend divisor    DVS_W-bit unsigned divisor
//   out_valid    result valid                out_ready  consumer takes result
//   quotient     floor(dividend/divisor)     remainder  dividend mod divisor
//   div_by_zero  result came from divisor == 0
// ---------------------------------------------------------------------------
module unsigned_div_seq #(
    parameter int DVD_W = 48,
    parameter int DVS_W = 24,
    parameter int CNT_W = $clog2(DVD_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           r_state;
    logic [DVS_W:0]   r_rem;        // partial remainder, one guard bit
    logic [DVD_W-1:0] r_shreg;      // dividend bits shift out, quotient bits shift in
    logic [DVS_W-1:0] r_divisor;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [DVD_W-1:0] r_quotient;
    logic [DVS_W-1:0] r_remainder;
    logic             r_div_by_zero;

    // One restoring step. The extra top bit of w_trial is the borrow:
    // when it is clear, the shifted remainder was >= divisor.
    logic [DVS_W+1:0] w_trial;
    logic             w_qbit;
    logic [DVS_W:0]   w_rem_nxt;
    logic [DVD_W-1:0] w_q_nxt;

    assign w_trial   = {r_rem, r_shreg[DVD_W-1]} - {2'b00, r_divisor};
    assign w_qbit    = ~w_trial[DVS_W+1];
    assign w_rem_nxt = w_qbit ? w_trial[DVS_W:0] : {r_rem[DVS_W-1:0], r_shreg[DVD_W-1]};
    assign w_q_nxt   = {r_shreg[DVD_W-2:0], w_qbit};

    // Values loaded into the shift register and counter on accept.
    logic [DVD_W-1:0] w_load_shreg;
    logic [CNT_W-1:0] w_load_cnt;

`ifdef UNSIGNED_DIV_EARLY_TERM_EN
    logic [CNT_W-1:0] w_lz;

    // Leading-zero count. The highest set bit is visited last, so it wins.
    // An all-zero dividend gives DVD_W.
    always_comb begin
        w_lz = CNT_W'(DVD_W);
        for (int i = 0; i < DVD_W; i++) begin
            if (dividend[i]) w_lz = CNT_W'(DVD_W - 1 - i);
        end
    end

    // Leading zeros would only produce zero quotient bits and keep the
    // remainder at 0. They are skipped here. At least one step always runs,
    // so a zero dividend still passes through CALC.
    assign w_load_shreg = dividend << w_lz;
    assign w_load_cnt   = (w_lz == CNT_W'(DVD_W)) ? CNT_W'(1) : (CNT_W'(DVD_W) - w_lz);
`else
    assign w_load_shreg = dividend;
    assign w_load_cnt   = CNT_W'(DVD_W);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rem         <= '0;
            r_shreg       <= '0;
            r_divisor     <= '0;
            r_cnt         <= '0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_divisor  <= divisor;
                        r_rem      <= '0;
                        r_shreg    <= w_load_shreg;
                        r_in_ready <= 1'b0;
                        if (divisor == '0) begin
                            r_quotient    <= '1;
                            r_remainder   <= '0;
                            r_div_by_zero <= 1'b1;
                            r_out_valid   <= 1'b1;
                            r_state       <= S_DONE;
                        end else begin
                            r_cnt   <= w_load_cnt;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= w_rem_nxt;
                    r_shreg <= w_q_nxt;
                    r_cnt   <= r_cnt - 1'b1;
                    // The visible outputs change only when the last step completes.
                    // Until then they keep the previous result.
                    if (r_cnt == CNT_W'(1)) begin
                        r_quotient    <= w_q_nxt;
                        r_remainder   <= w_rem_nxt[DVS_W-1:0];
                        r_div_by_zero <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_unsigned_div_seq.sv
// Self-checking bench for unsigned_div_seq at the default 48/24 widths.
module tb_unsigned_div_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] dividend;
    logic [23:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] quotient;
    logic [23:0] remainder;
    logic        div_by_zero;

    unsigned_div_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] dvd;
        logic [23:0] dvs;
        logic [47:0] q;
        logic [23:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs[10];
    int   n_pass;
    int   n_tot;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Cycle (counted from the accept cycle) in which out_valid first shows.
    function automatic int exp_lat(input logic [47:0] a, input logic [23:0] b);
        int lz;
        int n;
        if (b == 24'd0) return 1;
        lz = 48;
        for (int i = 47; i >= 0; i--) begin
            if (a[i]) begin
                lz = 47 - i;
                break;
            end
        end
`ifdef UNSIGNED_DIV_EARLY_TERM_EN
        n = (48 - lz < 1) ? 1 : 48 - lz;
`else
        n = 48 + 0 * lz;
`endif
        return n + 1;
    endfunction

    task automatic wait_ready(input string name);
        int k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, {63'd0, in_ready}, 64'd1);
    endtask

    // Present one operand pair for one cycle. Count cycles until out_valid
    // shows, giving up after 200 cycles.
    task automatic issue(input logic [47:0] a, input logic [23:0] b, output int lat);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        n_pass    = 0;
        n_tot     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        vecs[0] = '{48'd1000003,         24'd7,        48'd142857,        24'd4,        1'b0};
        vecs[1] = '{48'hFFFF_FFFF_FFFF,  24'hFF_FFFF,  48'h1000001,       24'd0,        1'b0};
        vecs[2] = '{48'd12345,           24'd0,        48'hFFFF_FFFF_FFFF, 24'd0,       1'b1};
        vecs[3] = '{48'd5,               24'd9,        48'd0,             24'd5,        1'b0};
        vecs[4] = '{48'd0,               24'd5,        48'd0,             24'd0,        1'b0};
        vecs[5] = '{48'hAB_CDEF,         24'hFF_FFFF,  48'd0,             24'hAB_CDEF,  1'b0};
        vecs[6] = '{48'h1234_5678_9ABC,  24'd1,        48'h1234_5678_9ABC, 24'd0,       1'b0};
        vecs[7] = '{48'd255,             24'd16,       48'd15,            24'd15,       1'b0};
        vecs[8] = '{48'd100,             24'd10,       48'd10,            24'd0,        1'b0};
        vecs[9] = '{48'h8000_0000_0000,  24'h80_0000,  48'h100_0000,      24'd0,        1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_in_ready",  {63'd0, in_ready},    64'd1);
        check("rst_out_valid", {63'd0, out_valid},   64'd0);
        check("rst_quotient",  {16'd0, quotient},    64'd0);
        check("rst_remainder", {40'd0, remainder},   64'd0);
        check("rst_dbz",       {63'd0, div_by_zero}, 64'd0);

        // out_ready with no result pending must not disturb an idle divider.
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_out_ready_in_ready",  {63'd0, in_ready},  64'd1);
        check("idle_out_ready_out_valid", {63'd0, out_valid}, 64'd0);

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            wait_ready($sformatf("v%0d_ready", i));
            issue(vecs[i].dvd, vecs[i].dvs, lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].dvd, vecs[i].dvs)));
            check($sformatf("v%0d_quotient", i), {16'd0, quotient}, {16'd0, vecs[i].q});
            check($sformatf("v%0d_remainder", i), {40'd0, remainder}, {40'd0, vecs[i].r});
            check($sformatf("v%0d_dbz", i), {63'd0, div_by_zero}, {63'd0, vecs[i].dbz});
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check($sformatf("v%0d_in_ready_after", i), {63'd0, in_ready}, 64'd1);
        end

        // Backpressure: hold the result for 10 cycles and try to sneak in an operand.
        wait_ready("bp_ready");
        issue(48'd1000003, 24'd7, lat);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                dividend = 48'd99;
                divisor  = 24'd0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_in_ready",  {63'd0, in_ready},  64'd0);
            check("bp_quotient",  {16'd0, quotient},  64'd142857);
            check("bp_remainder", {40'd0, remainder}, 64'd4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_in_ready",  {63'd0, in_ready},    64'd1);
        check("bp_release_out_valid", {63'd0, out_valid},   64'd0);
        check("bp_hold_quotient",     {16'd0, quotient},    64'd142857);
        check("bp_hold_dbz",          {63'd0, div_by_zero}, 64'd0);

        // Reset 20 cycles into CALC discards the pending result.
        dividend = 48'd1000003;
        divisor  = 24'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready",  {63'd0, in_ready},  64'd1);
        check("midrst_quotient",  {16'd0, quotient},  64'd0);
        check("midrst_remainder", {40'd0, remainder}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready("post_rst_ready");
        issue(48'd100, 24'd10, lat);
        check("post_rst_latency",   64'(lat), 64'(exp_lat(48'd100, 24'd10)));
        check("post_rst_quotient",  {16'd0, quotient},  64'd10);
        check("post_rst_remainder", {40'd0, remainder}, 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // When rst and in_valid are high together, rst wins. Without reset,
        // a zero divisor would finish in one cycle.
        rst      = 1'b1;
        dividend = 48'd7;
        divisor  = 24'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;
        check("rst_vs_valid_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_vs_valid_in_ready",  {63'd0, in_ready},  64'd1);

        // Back-to-back operations with out_ready tied high.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [47:0] a;
            logic [23:0] b;
            logic [47:0] eq;
            logic [23:0] er;
            case (i)
                0:       begin a = 48'd1000003; b = 24'd7;  eq = 48'd142857; er = 24'd4;  end
                1:       begin a = 48'd255;     b = 24'd16; eq = 48'd15;     er = 24'd15; end
                default: begin a = 48'd1;       b = 24'd1;  eq = 48'd1;      er = 24'd0;  end
            endcase
            wait_ready($sformatf("b2b%0d_ready", i));
            issue(a, b, lat);
            check($sformatf("b2b%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("b2b%0d_quotient", i),  {16'd0, quotient},  {16'd0, eq});
            check($sformatf("b2b%0d_remainder", i), {40'd0, remainder}, {40'd0, er});
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_final_in_ready", {63'd0, in_ready}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
